// File: rtl/fifo_pkg.sv
// fifo_pkg - shared defaults and width helpers for the synchronous FIFO.
// Rev 1.0
`default_nettype none

package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 8;

    // Occupancy needs one extra bit so that a completely full FIFO is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int DEFAULT_CNT_WIDTH = cnt_width(DEFAULT_DEPTH);

endpackage

`default_nettype wire

// File: rtl/fifo_mem.sv
// fifo_mem - register-array storage, one synchronous write port, one registered read port.
// Rev 1.0
`default_nettype none

module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the output register is reset; the array keeps whatever it held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/sync_fifo.sv
// sync_fifo - single-clock FIFO with registered read data, flags and overflow/underflow pulses.
// Rev 1.0
`default_nettype none

module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_ok;
    logic          rd_ok;
    logic [CW-1:0] count_nxt;

    // Flags gate acceptance, so a full FIFO still reads and an empty one still writes.
    always_comb begin
        wr_ok     = wr_en & ~full;
        rd_ok     = rd_en & ~empty;
        count_nxt = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count     <= count_nxt;
            full      <= (count_nxt == CW'(DEPTH));
            empty     <= (count_nxt == '0);
            rd_valid  <= rd_ok;
            overflow  <= wr_en & full;
            underflow <= rd_en & empty;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) u_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo - directed and randomized checks of sync_fifo against a queue model.
// Rev 1.0
`default_nettype none

module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] model_rd_data = '0;

    sync_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_state();
        check("rst_count",     32'(count),     32'd0);
        check("rst_empty",     32'(empty),     32'd1);
        check("rst_full",      32'(full),      32'd0);
        check("rst_rd_data",   32'(rd_data),   32'd0);
        check("rst_rd_valid",  32'(rd_valid),  32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        #1;
        check_reset_state();
        model_q.delete();
        model_rd_data = '0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One clock with the given request; the model applies the FIFO rules before the edge.
    task automatic step(input logic w, input logic [DW-1:0] wd, input logic r);
        bit m_full, m_empty, rd_acc, wr_acc;
        wr_en   = w;
        wr_data = wd;
        rd_en   = r;
        m_full  = (model_q.size() == DEPTH);
        m_empty = (model_q.size() == 0);
        rd_acc  = r && !m_empty;
        wr_acc  = w && !m_full;
        if (rd_acc) model_rd_data = model_q.pop_front();
        if (wr_acc) model_q.push_back(wd);
        @(posedge clk);
        #1;
        check("count",     32'(count),     32'(model_q.size()));
        check("full",      32'(full),      32'(model_q.size() == DEPTH));
        check("empty",     32'(empty),     32'(model_q.size() == 0));
        check("rd_valid",  32'(rd_valid),  32'(rd_acc));
        check("rd_data",   32'(rd_data),   32'(model_rd_data));
        check("overflow",  32'(overflow),  32'(w && m_full));
        check("underflow", 32'(underflow), 32'(r && m_empty));
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        do_reset();

        for (int i = 1; i <= 8; i++) step(1'b1, DW'(8'h11 * i), 1'b0);
        check("fill_full", 32'(full), 32'd1);

        step(1'b1, 8'h99, 1'b0);
        check("ovf_pulse", 32'(overflow), 32'd1);
        step(1'b0, 8'h00, 1'b0);
        check("ovf_clear", 32'(overflow), 32'd0);

        step(1'b1, 8'hEE, 1'b1);
        check("full_both_rd", 32'(rd_data), 32'h11);
        step(1'b1, 8'hEE, 1'b0);

        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_last", 32'(rd_data), 32'hEE);

        step(1'b0, 8'h00, 1'b1);
        check("udf_hold", 32'(rd_data), 32'hEE);

        step(1'b1, 8'h5A, 1'b1);
        check("empty_both_cnt", 32'(count), 32'd1);
        check("empty_both_nowt", 32'(rd_data), 32'hEE);
        step(1'b0, 8'h00, 1'b1);
        check("empty_both_rd", 32'(rd_data), 32'h5A);

        for (int i = 0; i < 3; i++) step(1'b1, DW'($urandom), 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, DW'($urandom), 1'b1);
        check("hold3_count", 32'(count), 32'd3);

        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        check("pre_rst_count", 32'(count), 32'd5);
        do_reset();
        step(1'b1, 8'hA5, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check("post_rst_word", 32'(rd_data), 32'hA5);

        for (int i = 0; i < 400; i++) begin
            int bias;
            bias = (i / 50) % 2;
            step(($urandom_range(9, 0) < (bias ? 7 : 3)),
                 DW'($urandom),
                 ($urandom_range(9, 0) < (bias ? 3 : 7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of each stored word.
REQ-002 Parameter DEPTH, default 8, SHALL set the number of entries; legal values are powers of two, 2 to 256.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 Port wr_en  input  1  SHALL be the write request.
REQ-006 Port wr_data  input  DATA_WIDTH  SHALL be the write word, sampled when a write is accepted.
REQ-007 Port rd_en  input  1  SHALL be the read request.
REQ-008 Port rd_data  output  DATA_WIDTH  SHALL be the registered read word.
REQ-009 Port rd_valid  output  1  SHALL mark that rd_data holds a newly read word.
REQ-010 Port full  output  1  SHALL be high when count equals DEPTH.
REQ-011 Port empty  output  1  SHALL be high when count equals 0.
REQ-012 Port count  output  $clog2(DEPTH)+1  SHALL be the current occupancy.
REQ-013 Port overflow  output  1  SHALL be a one-cycle pulse for a rejected write.
REQ-014 Port underflow  output  1  SHALL be a one-cycle pulse for a rejected read.

Function
REQ-015 A write SHALL be accepted when wr_en=1 and full=0: store wr_data at wr_ptr, then increment wr_ptr.
REQ-016 A read SHALL be accepted when rd_en=1 and empty=0: load the entry at rd_ptr into rd_data, then increment rd_ptr.
REQ-017 Read latency SHALL be one cycle: rd_data and rd_valid update on the edge where the read is accepted; rd_valid=0 in every other cycle.
REQ-018 rd_data SHALL hold its last value when no read is accepted.
REQ-019 Pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no gap.
REQ-020 count SHALL go +1 for write only, -1 for read only, and stay unchanged for both or neither.
REQ-021 Full, simultaneous wr_en and rd_en: the read SHALL be accepted, the write rejected, overflow pulsed, and count becomes DEPTH-1.
REQ-022 Empty, simultaneous wr_en and rd_en: the write SHALL be accepted, the read rejected, underflow pulsed, and count becomes 1; no write-through to rd_data.
REQ-023 Not full and not empty, simultaneous wr_en and rd_en: both SHALL be accepted.
REQ-024 full and empty SHALL be registered, decoded from next-state count, and valid in the same cycle as count.
REQ-025 Rejected operations SHALL NOT change the pointers, the memory, count or rd_data.

Reset
REQ-026 While reset_n=0, wr_ptr, rd_ptr, count, rd_data, rd_valid, overflow and underflow SHALL be 0, empty SHALL be 1, and full SHALL be 0.
REQ-027 Reset mid-operation SHALL discard all contents immediately; memory contents need not be cleared.
REQ-028 The first accepted operation SHALL occur on the first rising clk edge after reset_n deasserts.

Structure
REQ-029 Package fifo_pkg SHALL hold the default DATA_WIDTH and DEPTH and a count-width helper constant.
REQ-030 Storage SHALL be a sub-module fifo_mem: a register array with one synchronous write port and one synchronous read port, and no reset on the array.
REQ-031 Pointer, count, flag and pulse logic SHALL reside in sync_fifo.

Verification
REQ-032 Reset, then write 0x11..0x88 (8 writes): full=1, count=8, no overflow.
REQ-033 Read 8 times: rd_data is 0x11..0x88 in order, with rd_valid high one cycle after each rd_en; empty=1 at the end.
REQ-034 Write while full: overflow is a one-cycle pulse, count stays 8, and the next read still returns 0x11.
REQ-035 Read while empty: underflow pulses, rd_valid=0, and rd_data is unchanged.
REQ-036 With count=3, hold wr_en and rd_en for 20 cycles: count stays 3, pointers wrap, and data order is preserved.
REQ-037 Assert reset_n=0 at count=5, then release: empty=1, count=0, and the next write/read pair returns the new word.
